// File: rtl/zld_xc9_pkg.sv
// -----------------------------------------------------------------------------
// zld_xc9_pkg -- token layout and decoder state encodings for the zero
// run-length codec. The zero run-length encoder imports the same package, so
// the token layout is defined only here.
//
// Token layout (TOK_W = 4):
//   bit RUN_BIT (3) : 1 = run of zeros, 0 = literal symbol
//   bits 2:0        : literal value, or (run length - 1)
// Symbols are SYM_W = 3 bits wide.
// -----------------------------------------------------------------------------
package zld_xc9_pkg;

    localparam int TOK_W    = 4;
    localparam int SYM_W    = 3;
    localparam int RUN_BIT  = 3;
    localparam int ZCOUNT_W = 16;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    function automatic logic tok_is_run(input logic [TOK_W-1:0] tok);
        return tok[RUN_BIT];
    endfunction

    function automatic logic [SYM_W-1:0] tok_payload(input logic [TOK_W-1:0] tok);
        return tok[SYM_W-1:0];
    endfunction

endpackage

// File: rtl/zld_xc9_fsm.sv
// -----------------------------------------------------------------------------
// zld_xc9_fsm -- control path of the zero run-length decoder.
// Owns the IDLE/RUN state and the remaining-zero counter, produces the
// backpressure to the token producer and the select strobes that steer the
// output register held in the top level.
//
// Ports:
//   clock, reset : clock, asynchronous active-high reset
//   i_d, i_v     : incoming token and its valid
//   o_v, o_b     : current output-register valid and consumer backpressure
//   i_b          : backpressure to the token producer (combinational)
//   load         : a token is accepted this cycle
//   step         : RUN state emits the next zero of the run this cycle
//   drain        : output consumed in IDLE with nothing new to load
// -----------------------------------------------------------------------------
module zld_xc9_fsm
    import zld_xc9_pkg::*;
(
    input  logic             clock,
    input  logic             reset,
    input  logic [TOK_W-1:0] i_d,
    input  logic             i_v,
    input  logic             o_v,
    input  logic             o_b,
    output logic             i_b,
    output logic             load,
    output logic             step,
    output logic             drain
);

    state_t           state_reg;
    logic [SYM_W-1:0] cnt_reg;
    logic             consumed;

    assign consumed = o_v & ~o_b;

    always_comb begin
        i_b   = 1'b1;
        load  = 1'b0;
        step  = 1'b0;
        drain = 1'b0;
        if (state_reg == ST_RUN) begin
            // Producer is held off for the whole run; only the zeros move.
            i_b  = 1'b1;
            step = consumed;
        end else begin
            // A token may enter when the output register is empty or drains
            // this very cycle, which keeps back-to-back tokens bubble-free.
            i_b   = o_v & o_b;
            load  = i_v & ~(o_v & o_b);
            drain = consumed & ~(i_v & ~(o_v & o_b));
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_reg <= ST_IDLE;
            cnt_reg   <= '0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (load && tok_is_run(i_d)) begin
                        // First zero goes out with the load; cnt holds the
                        // zeros still owed after it.
                        cnt_reg <= tok_payload(i_d);
                        if (tok_payload(i_d) != '0) begin
                            state_reg <= ST_RUN;
                        end
                    end
                end
                ST_RUN: begin
                    if (consumed) begin
                        cnt_reg <= cnt_reg - 3'd1;
                        if (cnt_reg == 3'd1) begin
                            state_reg <= ST_IDLE;
                        end
                    end
                end
                default: begin
                    state_reg <= ST_IDLE;
                    cnt_reg   <= '0;
                end
            endcase
        end
    end

endmodule

// File: rtl/zld_xc9.sv
// -----------------------------------------------------------------------------
// zld_xc9 -- zero run-length decoder.
// Expands 4-bit tokens into 3-bit symbols: a literal token yields one symbol,
// a run token yields (payload + 1) zero symbols. Both sides use valid plus
// backpressure handshakes; a transfer happens when valid=1 and backpressure=0.
// The output register is loaded on the same edge that accepts a token, so the
// first symbol appears right after acceptance and a busy consumer stalls the
// decoder without losing data.
//
// Ports:
//   clock   : clock, all state on rising edge
//   reset   : asynchronous active-high reset
//   i_d     : [3:0] token; i_v token valid; i_b backpressure to producer
//   o_d     : [2:0] symbol; o_v symbol valid; o_b backpressure from consumer
//   zcount  : [15:0] saturating count of zero symbols transferred
//             (present only when ZLD_XC9_STATS_EN is defined)
//
// Build option: define ZLD_XC9_STATS_EN to add the zcount statistics port.
// -----------------------------------------------------------------------------
module zld_xc9
    import zld_xc9_pkg::*;
(
    input  logic                clock,
    input  logic                reset,
    input  logic [TOK_W-1:0]    i_d,
    input  logic                i_v,
    output logic                i_b,
    output logic [SYM_W-1:0]    o_d,
    output logic                o_v,
    input  logic                o_b
`ifdef ZLD_XC9_STATS_EN
    ,
    output logic [ZCOUNT_W-1:0] zcount
`endif
);

    logic [SYM_W-1:0] o_d_reg;
    logic             o_v_reg;
    logic             load;
    logic             step;
    logic             drain;

    zld_xc9_fsm u_fsm (
        .clock (clock),
        .reset (reset),
        .i_d   (i_d),
        .i_v   (i_v),
        .o_v   (o_v_reg),
        .o_b   (o_b),
        .i_b   (i_b),
        .load  (load),
        .step  (step),
        .drain (drain)
    );

    // Output register; any hold case (o_v=1, o_b=1) falls through untouched.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            o_v_reg <= 1'b0;
            o_d_reg <= '0;
        end else if (load) begin
            o_v_reg <= 1'b1;
            o_d_reg <= tok_is_run(i_d) ? '0 : tok_payload(i_d);
        end else if (step) begin
            o_v_reg <= 1'b1;
            o_d_reg <= '0;
        end else if (drain) begin
            o_v_reg <= 1'b0;
        end
    end

    assign o_d = o_d_reg;
    assign o_v = o_v_reg;

`ifdef ZLD_XC9_STATS_EN
    logic [ZCOUNT_W-1:0] zcount_reg;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            zcount_reg <= '0;
        end else if (o_v_reg && !o_b && (o_d_reg == '0) && (zcount_reg != '1)) begin
            zcount_reg <= zcount_reg + 1'b1;
        end
    end

    assign zcount = zcount_reg;
`endif

endmodule
